// File: rtl/oserdes_pkg.sv
// Shared constants and types for the bonded multi-lane serializer.
package oserdes_pkg;

    localparam int unsigned MIN_WIDTH = 3;
    localparam int unsigned MAX_WIDTH = 10;

    function automatic int unsigned cnt_width(input int unsigned data_width);
        return $clog2(data_width);
    endfunction

    // Sized for the widest legal word so one type serves every configuration.
    typedef logic [$clog2(MAX_WIDTH)-1:0] cnt_t;

    typedef enum logic {
        ShiftLsbFirst,
        ShiftMsbFirst
    } shift_dir_e;

endpackage

// File: rtl/oserdes_lane.sv
// One serializer lane: holding register plus shift register, driven by shared strobes.
module oserdes_lane
    import oserdes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter shift_dir_e  Dir        = ShiftLsbFirst
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  boundary_i,
    input  logic                  load_i,
    input  logic                  hold_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  bit_o
);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    always_comb begin
        shift_d = shift_q;
        hold_d  = hold_q;
        if (boundary_i) begin
            // A word presented on the boundary bypasses the holding register.
            if (load_i) begin
                shift_d = data_i;
            end else if (hold_valid_i) begin
                shift_d = hold_q;
            end else begin
                shift_d = '0;
            end
        end else begin
            shift_d = (Dir == ShiftLsbFirst) ? (shift_q >> 1) : (shift_q << 1);
            if (load_i) begin
                hold_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            hold_q  <= '0;
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
        end
    end

    assign bit_o = (Dir == ShiftLsbFirst) ? shift_q[0] : shift_q[DATA_WIDTH-1];

endmodule

// File: rtl/oserdes_bonded_multi.sv
// Multi-lane bonded serializer: shared bit counter, bond-sync realignment, hold/flag control.
module oserdes_bonded_multi
    import oserdes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_CH     = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         load_word,
    input  logic                         channel_bond_sync_in,
    output logic [NUM_CH-1:0]            data_out,
    output logic                         oe_out,
    output logic                         channel_bond_sync_out,
    output logic                         word_ready,
    output logic                         underrun,
    output logic                         overflow
);

    localparam cnt_t       LastCnt = cnt_t'(DATA_WIDTH - 1);
    localparam shift_dir_e Dir     = MSB_FIRST ? ShiftMsbFirst : ShiftLsbFirst;

    if (DATA_WIDTH < MIN_WIDTH || DATA_WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("oserdes_bonded_multi: DATA_WIDTH out of range");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("oserdes_bonded_multi: NUM_CH out of range");
    end

    cnt_t cnt_q, cnt_d;
    logic sync_q, sync_d;
    logic hold_valid_q, hold_valid_d;
    logic oe_q, oe_d;
    logic sync_out_q, sync_out_d;
    logic underrun_q, underrun_d;
    logic overflow_q, overflow_d;
    logic boundary;

    // Counter wrap and a bond-sync rising edge collapse into one boundary.
    assign boundary = (cnt_q == LastCnt) || (channel_bond_sync_in && !sync_q);

    always_comb begin
        cnt_d        = cnt_q;
        sync_d       = channel_bond_sync_in;
        hold_valid_d = hold_valid_q;
        oe_d         = oe_q;
        sync_out_d   = 1'b0;
        underrun_d   = 1'b0;
        overflow_d   = 1'b0;
        if (boundary) begin
            cnt_d        = '0;
            hold_valid_d = 1'b0;
            oe_d         = load_word || hold_valid_q;
            underrun_d   = !(load_word || hold_valid_q);
            sync_out_d   = channel_bond_sync_in;
        end else begin
            cnt_d      = cnt_q + cnt_t'(1);
            overflow_d = load_word && hold_valid_q;
            if (load_word) begin
                hold_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q        <= LastCnt;
            sync_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            oe_q         <= 1'b0;
            sync_out_q   <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            hold_valid_q <= hold_valid_d;
            oe_q         <= oe_d;
            sync_out_q   <= sync_out_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        oserdes_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .Dir       (Dir)
        ) u_lane (
            .clk_in      (clk_in),
            .reset       (reset),
            .boundary_i  (boundary),
            .load_i      (load_word),
            .hold_valid_i(hold_valid_q),
            .data_i      (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .bit_o       (data_out[c])
        );
    end

    assign oe_out                = oe_q;
    assign channel_bond_sync_out = sync_out_q;
    assign word_ready            = !hold_valid_q;
    assign underrun              = underrun_q;
    assign overflow              = overflow_q;

endmodule

// File: tb/tb_oserdes_bonded_multi.sv
// Directed self-checking bench for oserdes_bonded_multi (4x2 LSB-first and 10x4 MSB-first).
module tb_oserdes_bonded_multi;

    logic       clk;
    int         n_assert = 0;
    int         n_fail   = 0;

    // 4-bit, 2-lane, LSB-first instance
    logic       rst, load, sync;
    logic [7:0] din;
    logic [1:0] dout;
    logic       oe, so, wr, ur, of;

    // 10-bit, 4-lane, MSB-first instance
    logic        rst10, load10, sync10;
    logic [39:0] din10;
    logic [3:0]  dout10;
    logic        oe10, so10, wr10, ur10, of10;

    oserdes_bonded_multi #(.DATA_WIDTH(4), .NUM_CH(2), .MSB_FIRST(1'b0)) dut (
        .clk_in               (clk),
        .reset                (rst),
        .data_in              (din),
        .load_word            (load),
        .channel_bond_sync_in (sync),
        .data_out             (dout),
        .oe_out               (oe),
        .channel_bond_sync_out(so),
        .word_ready           (wr),
        .underrun             (ur),
        .overflow             (of)
    );

    oserdes_bonded_multi #(.DATA_WIDTH(10), .NUM_CH(4), .MSB_FIRST(1'b1)) dut10 (
        .clk_in               (clk),
        .reset                (rst10),
        .data_in              (din10),
        .load_word            (load10),
        .channel_bond_sync_in (sync10),
        .data_out             (dout10),
        .oe_out               (oe10),
        .channel_bond_sync_out(so10),
        .word_ready           (wr10),
        .underrun             (ur10),
        .overflow             (of10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 1'b0; sync = 1'b0; din = '0;
        rst10 = 1'b0; load10 = 1'b0; sync10 = 1'b0; din10 = '0;
        step();
        step();
        n_assert++;
        if ({dout, oe, so, wr, ur, of} !== {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset4: got %b expected %b", {dout, oe, so, wr, ur, of}, 7'b0000100);
        end
        n_assert++;
        if ({dout10, oe10, so10, wr10, ur10, of10} !== {4'b0000, 5'b00100}) begin
            n_fail++;
            $display("FAIL reset10: got %b expected %b",
                     {dout10, oe10, so10, wr10, ur10, of10}, 9'b000000100);
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_d [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
        sync = 1'b1; load = 1'b1; din = {4'b0011, 4'b1000};
        rst = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                n_assert++;
                if (dout !== exp_d[k]) begin
                    n_fail++;
                    $display("FAIL basic_data w=%0d k=%0d: got %b expected %b", w, k, dout, exp_d[k]);
                end
                n_assert++;
                if ({oe, so, wr} !== {1'b1, (k == 0), (k == 0)}) begin
                    n_fail++;
                    $display("FAIL basic_ctrl w=%0d k=%0d: got %b expected %b",
                             w, k, {oe, so, wr}, {1'b1, (k == 0), (k == 0)});
                end
            end
        end
    endtask

    task automatic test_underrun();
        logic [1:0] exp_d [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
        int         ur_count = 0;
        load = 1'b0;
        // Word parked in the holding register drains first.
        for (int k = 0; k < 4; k++) begin
            step();
            n_assert++;
            if ({dout, oe, ur, wr} !== {exp_d[k], 1'b1, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL drain k=%0d: got %b expected %b", k, {dout, oe, ur, wr},
                         {exp_d[k], 3'b101});
            end
        end
        for (int i = 0; i < 96; i++) begin
            step();
            if (ur) ur_count++;
            n_assert++;
            if ({dout, oe, ur, wr} !== {2'b00, 1'b0, (i % 4 == 0), 1'b1}) begin
                n_fail++;
                $display("FAIL underrun i=%0d: got %b expected %b", i, {dout, oe, ur, wr},
                         {3'b000, (i % 4 == 0), 1'b1});
            end
        end
        n_assert++;
        if (ur_count != 24) begin
            n_fail++;
            $display("FAIL underrun_count: got %0d expected 24", ur_count);
        end
    endtask

    task automatic test_realign();
        logic [1:0] exp_a [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
        logic [1:0] exp_b [4] = '{2'b01, 2'b11, 2'b10, 2'b10};
        load = 1'b1; din = {4'b1001, 4'b0110};
        step();
        n_assert++;
        if ({dout, oe, so} !== {exp_a[0], 2'b11}) begin
            n_fail++;
            $display("FAIL realign_w1 k=0: got %b expected %b", {dout, oe, so}, {exp_a[0], 2'b11});
        end
        load = 1'b0; sync = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            n_assert++;
            if ({dout, oe, so} !== {exp_a[k], 2'b10}) begin
                n_fail++;
                $display("FAIL realign_w1 k=%0d: got %b expected %b", k, {dout, oe, so},
                         {exp_a[k], 2'b10});
            end
        end
        load = 1'b1; din = {4'b1100, 4'b0101};
        step();
        n_assert++;
        if ({dout, oe, so} !== {2'b01, 2'b10}) begin
            n_fail++;
            $display("FAIL realign_w2 k=0: got %b expected %b", {dout, oe, so}, 4'b0110);
        end
        load = 1'b0;
        step();
        n_assert++;
        if ({dout, so} !== 3'b000) begin
            n_fail++;
            $display("FAIL realign_w2 k=1: got %b expected %b", {dout, so}, 3'b000);
        end
        // Raise bond sync at cnt==1 with a fresh word: old word is cut short.
        sync = 1'b1; load = 1'b1; din = {4'b1110, 4'b0011};
        for (int k = 0; k < 4; k++) begin
            step();
            load = 1'b0;
            n_assert++;
            if ({dout, oe, so} !== {exp_b[k], 1'b1, (k == 0)}) begin
                n_fail++;
                $display("FAIL realign_w3 k=%0d: got %b expected %b", k, {dout, oe, so},
                         {exp_b[k], 1'b1, (k == 0)});
            end
        end
        step();
        n_assert++;
        if ({oe, so, ur} !== 3'b011) begin
            n_fail++;
            $display("FAIL realign_tail: got %b expected %b", {oe, so, ur}, 3'b011);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_d [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
        load = 1'b1; din = {4'hA, 4'hA};
        step();
        n_assert++;
        if ({of, wr} !== 2'b00) begin
            n_fail++;
            $display("FAIL overflow_first: got %b expected %b", {of, wr}, 2'b00);
        end
        din = {4'h5, 4'h5};
        step();
        n_assert++;
        if ({of, wr} !== 2'b10) begin
            n_fail++;
            $display("FAIL overflow_pulse: got %b expected %b", {of, wr}, 2'b10);
        end
        load = 1'b0;
        step();
        n_assert++;
        if (of !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b expected 0", of);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_assert++;
            if ({dout, oe, wr, of} !== {exp_d[k], 3'b110}) begin
                n_fail++;
                $display("FAIL overflow_word k=%0d: got %b expected %b", k, {dout, oe, wr, of},
                         {exp_d[k], 3'b110});
            end
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; din = {4'hF, 4'hF};
        step();
        load = 1'b0;
        n_assert++;
        if ({dout, oe} !== 3'b111) begin
            n_fail++;
            $display("FAIL midreset_pre: got %b expected %b", {dout, oe}, 3'b111);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        n_assert++;
        if ({dout, oe, so, wr} !== 5'b00001) begin
            n_fail++;
            $display("FAIL midreset_async: got %b expected %b", {dout, oe, so, wr}, 5'b00001);
        end
        load = 1'b1; din = {4'b0011, 4'b1000};
        #1;
        rst = 1'b1;
        step();
        n_assert++;
        if ({dout, oe, so} !== 4'b1011) begin
            n_fail++;
            $display("FAIL midreset_restart: got %b expected %b", {dout, oe, so}, 4'b1011);
        end
        load = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [9:0] w = 10'h2A5;
        sync10 = 1'b1; load10 = 1'b1; din10 = {4{10'h2A5}};
        rst10 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            n_assert++;
            if ({dout10, oe10, so10} !== {{4{w[9 - (n % 10)]}}, 1'b1, (n % 10 == 0)}) begin
                n_fail++;
                $display("FAIL msb_first n=%0d: got %b expected %b", n, {dout10, oe10, so10},
                         {{4{w[9 - (n % 10)]}}, 1'b1, (n % 10 == 0)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_realign();
        test_overflow();
        test_reset_mid();
        test_msb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
